// File: rtl/hps_cmd_pkg.sv
// hps_cmd_pkg: opcode offsets and EXT_BUS bit map shared by the hps_cmd_bridge files.
// Optional feature macro used by importers: HPS_CMD_OVERRUN_CNT_EN.
package hps_cmd_pkg;
    typedef logic [15:0] word_t;
    localparam int OFS_GET_STATUS  = 0;
    localparam int OFS_GET_PENDING = 1;
    localparam int OFS_SET         = 2;
    localparam int DOUT_LSB    = 0;
    localparam int DIN_LSB     = 16;
    localparam int DOUT_EN_BIT = 32;
    localparam int STROBE_BIT  = 33;
    localparam int ENABLE_BIT  = 34;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/hps_cmd_chan.sv
// hps_cmd_chan: one command channel holding the committed argument and the req/ack handshake.
// HPS_CMD_OVERRUN_CNT_EN adds a saturating dropped-command counter.
module hps_cmd_chan
    import hps_cmd_pkg::*;
#(
    parameter int ARG_WORDS = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   commit,
    input  logic [16*ARG_WORDS-1:0] data,
    input  logic                   ack,
    output logic                   req,
    output logic [16*ARG_WORDS-1:0] arg
`ifdef HPS_CMD_OVERRUN_CNT_EN
    ,
    output logic [7:0]             overrun
`endif
);
    logic accept;

    // A commit landing in the same cycle as the ack wins, so req stays high.
    assign accept = commit && (!req || ack);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req <= 1'b0;
            arg <= '0;
        end else begin
            req <= accept || (req && !ack);
            if (accept) arg <= data;
        end
    end

`ifdef HPS_CMD_OVERRUN_CNT_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) overrun <= 8'd0;
        else if (commit && !accept && overrun != 8'hFF) overrun <= overrun + 8'd1;
    end
`endif
endmodule

// File: rtl/hps_cmd_bridge.sv
// hps_cmd_bridge: HPS extension-bus endpoint decoding GET_STATUS, GET_PENDING and per-channel SET commands.
// HPS_CMD_OVERRUN_CNT_EN enables per-channel overrun counters and their GET_PENDING readback.
module hps_cmd_bridge
    import hps_cmd_pkg::*;
#(
    parameter logic [7:0] CMD_BASE     = 8'hF0,
    parameter int         NUM_CH       = 4,
    parameter int         ARG_WORDS    = 2,
    parameter int         STATUS_WORDS = 7
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    inout  wire  [35:0]                     EXT_BUS,
    input  logic                            hps_rise,
    input  logic [16*STATUS_WORDS-1:0]      status_in,
    output logic [NUM_CH-1:0]               cmd_req,
    input  logic [NUM_CH-1:0]               cmd_ack,
    output logic [16*ARG_WORDS*NUM_CH-1:0]  cmd_arg
`ifdef HPS_CMD_OVERRUN_CNT_EN
    ,
    output logic [8*NUM_CH-1:0]             overrun_cnt
`endif
);
    localparam int          WC_W  = $clog2(max_int(ARG_WORDS, STATUS_WORDS) + 2);
    localparam logic [15:0] OP_LO = 16'(CMD_BASE);
    localparam logic [15:0] OP_HI = 16'(int'(CMD_BASE) + 1 + NUM_CH);

    word_t                  io_dout, io_din, opcode, op_ofs, rd_word;
    logic                   dout_en, io_strobe, io_enable, armed, strobe_ok;
    logic                   in_range, is_set, req_sel;
    logic [WC_W-1:0]        wc;
    logic [7:0]             rise_cnt;
    logic                   rise_q, rise_p;
    word_t                  snap [STATUS_WORDS];
    word_t                  stg [ARG_WORDS];
    logic [16*ARG_WORDS-1:0] staged;
    logic [NUM_CH-1:0]      commit;
    int                     wn;

    assign EXT_BUS[DOUT_LSB +: 16] = io_dout;
    assign EXT_BUS[DOUT_EN_BIT]    = dout_en;
    assign io_din    = EXT_BUS[DIN_LSB +: 16];
    assign io_strobe = EXT_BUS[STROBE_BIT];
    assign io_enable = EXT_BUS[ENABLE_BIT];

    // Decoding is held off after reset until the host has idled io_enable once.
    assign strobe_ok = armed && io_enable && io_strobe;
    assign in_range  = io_din >= OP_LO && io_din <= OP_HI;
    assign op_ofs    = opcode - OP_LO;
    assign is_set    = op_ofs >= 16'(OFS_SET) && op_ofs < 16'(OFS_SET + NUM_CH);

`ifdef HPS_CMD_OVERRUN_CNT_EN
    localparam int NPAIR = (NUM_CH + 1) / 2;
    logic [16*NPAIR-1:0] ovr_pad;
    assign ovr_pad = (16*NPAIR)'(overrun_cnt);
`endif

    always_comb begin
        wn      = int'(wc);
        req_sel = 1'b0;
        commit  = '0;
        rd_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            req_sel   = (op_ofs == 16'(OFS_SET + k)) ? cmd_req[k] : req_sel;
            commit[k] = strobe_ok && wn == ARG_WORDS && op_ofs == 16'(OFS_SET + k);
        end
        // The final argument word bypasses staging and goes straight into the commit.
        for (int j = 0; j < ARG_WORDS; j++)
            staged[16*j +: 16] = (j == ARG_WORDS - 1) ? io_din : stg[j];
        if (op_ofs == 16'(OFS_GET_STATUS)) begin
            for (int i = 0; i < STATUS_WORDS; i++)
                if (wn == i + 1) rd_word = (i == 0) ? status_in[15:0] : snap[i];
        end else if (op_ofs == 16'(OFS_GET_PENDING)) begin
            if (wn == 1) rd_word = 16'(cmd_req);
`ifdef HPS_CMD_OVERRUN_CNT_EN
            for (int p = 0; p < NPAIR; p++)
                if (wn == p + 2) rd_word = ovr_pad[16*p +: 16];
`endif
        end else if (is_set && wn <= ARG_WORDS) begin
            rd_word = {15'd0, req_sel};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            dout_en  <= 1'b0;
            io_dout  <= '0;
            wc       <= '0;
            opcode   <= '0;
            rise_q   <= 1'b0;
            rise_p   <= 1'b0;
            rise_cnt <= 8'd0;
            for (int i = 0; i < STATUS_WORDS; i++) snap[i] <= '0;
            for (int j = 0; j < ARG_WORDS; j++) stg[j] <= '0;
        end else begin
            rise_q <= hps_rise;
            rise_p <= rise_q;
            if (rise_q != rise_p) rise_cnt <= rise_cnt + 8'd1;
            if (!io_enable) begin
                armed   <= 1'b1;
                dout_en <= 1'b0;
                io_dout <= '0;
                wc      <= '0;
                opcode  <= '0;
                for (int j = 0; j < ARG_WORDS; j++) stg[j] <= '0;
            end else if (strobe_ok) begin
                wc <= (&wc) ? wc : wc + 1'b1;
                if (wc == '0) begin
                    opcode  <= io_din;
                    dout_en <= in_range;
                    io_dout <= in_range ? {8'd0, rise_cnt} : 16'd0;
                end else begin
                    io_dout <= rd_word;
                    if (is_set)
                        for (int j = 0; j < ARG_WORDS; j++)
                            if (wn == j + 1) stg[j] <= io_din;
                    // Whole status vector is frozen on word 1 so later words are coherent.
                    if (op_ofs == 16'(OFS_GET_STATUS) && wn == 1)
                        for (int i = 0; i < STATUS_WORDS; i++) snap[i] <= status_in[16*i +: 16];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        hps_cmd_chan #(.ARG_WORDS(ARG_WORDS)) u_chan (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .commit  (commit[k]),
            .data    (staged),
            .ack     (cmd_ack[k]),
            .req     (cmd_req[k]),
            .arg     (cmd_arg[16*ARG_WORDS*k +: 16*ARG_WORDS])
`ifdef HPS_CMD_OVERRUN_CNT_EN
            ,
            .overrun (overrun_cnt[8*k +: 8])
`endif
        );
    end
endmodule

// File: tb/tb_hps_cmd_bridge.sv
// tb_hps_cmd_bridge: scoreboard bench for hps_cmd_bridge with a transaction-level reference model.
// Build with HPS_CMD_OVERRUN_CNT_EN to also cover the overrun counters.
module tb_hps_cmd_bridge;
    localparam logic [7:0]  CMD_BASE = 8'hF0;
    localparam int          NUM_CH   = 4;
    localparam int          AW       = 2;
    localparam int          SW       = 7;
    localparam int          NPAIR    = (NUM_CH + 1) / 2;
    localparam int          AWID     = 16 * AW * NUM_CH;
    localparam logic [15:0] OP_ST    = 16'(CMD_BASE);
    localparam logic [15:0] OP_PD    = OP_ST + 16'd1;
    localparam logic [15:0] OP_SET0  = OP_ST + 16'd2;

    typedef struct packed { logic en; logic [15:0] d; } exp_t;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              hps_rise = 1'b0;
    logic              strobe = 1'b0;
    logic              enable = 1'b0;
    logic [15:0]       din = 16'd0;
    logic [16*SW-1:0]  status_in = '0;
    logic [NUM_CH-1:0] cmd_ack = '0;
    logic [NUM_CH-1:0] cmd_req;
    logic [AWID-1:0]   cmd_arg;
    wire  [35:0]       ext_bus;
    wire  [15:0]       io_dout = ext_bus[15:0];
    wire               dout_en = ext_bus[32];
`ifdef HPS_CMD_OVERRUN_CNT_EN
    logic [8*NUM_CH-1:0] overrun_cnt;
`endif

    assign ext_bus[31:16] = din;
    assign ext_bus[33]    = strobe;
    assign ext_bus[34]    = enable;
    assign ext_bus[35]    = 1'b0;

    hps_cmd_bridge #(.CMD_BASE(CMD_BASE), .NUM_CH(NUM_CH), .ARG_WORDS(AW), .STATUS_WORDS(SW)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .EXT_BUS     (ext_bus),
        .hps_rise    (hps_rise),
        .status_in   (status_in),
        .cmd_req     (cmd_req),
        .cmd_ack     (cmd_ack),
        .cmd_arg     (cmd_arg)
`ifdef HPS_CMD_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int                total = 0;
    int                bad = 0;
    exp_t              expq[$];
    logic [15:0]       dq[$];
    logic [NUM_CH-1:0] req_m = '0;
    logic [AWID-1:0]   arg_m = '0;
    int                ovr_m[NUM_CH];
    logic [7:0]        rise_m = 8'd0;
    logic              stb_q = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [15:0] op);
        return int'(op) >= int'(CMD_BASE) && int'(op) <= int'(CMD_BASE) + 1 + NUM_CH;
    endfunction

    function automatic logic [8*NUM_CH-1:0] ovr_flat();
        logic [8*NUM_CH-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[8*k +: 8] = 8'(ovr_m[k]);
        return f;
    endfunction

    function automatic logic [15:0] pend_word(input int i);
`ifdef HPS_CMD_OVERRUN_CNT_EN
        int p;
        p = i - 2;
        if (p < NPAIR)
            return {(2*p + 1 < NUM_CH) ? 8'(ovr_m[2*p + 1]) : 8'd0, 8'(ovr_m[2*p])};
`endif
        return 16'd0;
    endfunction

    // Every strobe pushes the response expected on the bus the following cycle.
    always @(posedge clk_sys) stb_q <= strobe;

    always @(negedge clk_sys) begin : monitor
        exp_t e;
        if (stb_q) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: bus output with no expected entry, io_dout=%0h", io_dout);
            end else begin
                e = expq.pop_front();
                check("dout_en", dout_en, e.en);
                check("io_dout", io_dout, e.d);
            end
        end
        check("cmd_req", cmd_req, req_m);
        check("cmd_arg", cmd_arg, arg_m);
`ifdef HPS_CMD_OVERRUN_CNT_EN
        check("overrun_cnt", overrun_cnt, ovr_flat());
`endif
    end

    task automatic word(input logic [15:0] w, input logic en_e, input logic [15:0] d_e);
        exp_t e;
        e.en = en_e;
        e.d  = d_e;
        expq.push_back(e);
        din    = w;
        strobe = 1'b1;
        @(posedge clk_sys);
        #1;
        strobe = 1'b0;
    endtask

    task automatic txn(input logic [15:0] op, input int n, input bit ack_last, input bit keep_en);
        bit          rng, set_last;
        int          k;
        logic [15:0] w, e;
        logic [15:0] snapm [SW];
        logic [15:0] stg [AW];
        rng = in_range(op);
        k = int'(op) - int'(CMD_BASE) - 2;
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? op : ((dq.size() > 0) ? dq.pop_front() : 16'($urandom));
            if (i == 0) e = rng ? {8'd0, rise_m} : 16'd0;
            else if (!rng) e = 16'd0;
            else if (op == OP_ST) begin
                if (i == 1) for (int s = 0; s < SW; s++) snapm[s] = status_in[16*s +: 16];
                e = (i <= SW) ? snapm[i-1] : 16'd0;
            end else if (op == OP_PD) e = (i == 1) ? 16'(req_m) : pend_word(i);
            else begin
                e = (i <= AW) ? {15'd0, req_m[k]} : 16'd0;
                if (i <= AW) stg[i-1] = w;
            end
            set_last = rng && k >= 0 && i == AW;
            if (set_last && ack_last) cmd_ack[k] = 1'b1;
            word(w, rng, e);
            cmd_ack = '0;
            if (set_last) begin
                if (!req_m[k] || ack_last) begin
                    req_m[k] = 1'b1;
                    for (int j = 0; j < AW; j++) arg_m[16*(k*AW + j) +: 16] = stg[j];
                end else if (ovr_m[k] < 255) ovr_m[k]++;
            end
            for (int s = 0; s < SW; s++) status_in[16*s +: 16] = 16'($urandom);
        end
        if (!keep_en) begin
            enable = 1'b0;
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic toggle(input int n);
        for (int i = 0; i < n; i++) begin
            hps_rise = ~hps_rise;
            rise_m++;
            @(posedge clk_sys);
            #1;
        end
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_ack(input int k);
        cmd_ack[k] = 1'b1;
        @(posedge clk_sys);
        #1;
        cmd_ack = '0;
        req_m[k] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_io_dout"}, io_dout, 0);
        check({tag, "_dout_en"}, dout_en, 0);
        check({tag, "_cmd_req"}, cmd_req, 0);
        check({tag, "_cmd_arg"}, cmd_arg, 0);
`ifdef HPS_CMD_OVERRUN_CNT_EN
        check({tag, "_overrun"}, overrun_cnt, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_CH; k++) ovr_m[k] = 0;
        for (int s = 0; s < SW; s++) status_in[16*s +: 16] = 16'($urandom);
        repeat (3) @(posedge clk_sys);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;

        toggle(3);
        txn(OP_ST, 1, 0, 0);
        txn(OP_ST, SW + 3, 0, 0);

        dq = {16'h1234, 16'h5678};
        txn(OP_SET0 + 16'd2, AW + 1, 0, 0);
        check("ch2_arg", cmd_arg[16*(2*AW) +: 32], 32'h5678_1234);
        check("ch2_req", cmd_req[2], 1'b1);
        pulse_ack(2);
        check("ch2_req_after_ack", cmd_req[2], 1'b0);

        txn(OP_SET0, AW + 1, 0, 0);
        txn(OP_SET0, AW + 1, 0, 0);
`ifdef HPS_CMD_OVERRUN_CNT_EN
        check("ch0_overrun", overrun_cnt[7:0], 8'd1);
`endif
        txn(OP_SET0, AW + 1, 1, 0);
        check("ch0_req_kept", cmd_req[0], 1'b1);
        pulse_ack(0);

        txn(OP_SET0 + 16'd1, AW, 0, 0);
        check("ch1_abort_req", cmd_req[1], 1'b0);
        pulse_ack(1);

        txn(16'(int'(CMD_BASE) + 2 + NUM_CH), 3, 0, 0);
        txn(16'(int'(CMD_BASE) - 1), 2, 0, 0);

        txn(OP_SET0 + 16'd3, AW + 1, 0, 0);
        txn(OP_SET0 + 16'd3, AW + 1, 0, 0);
        txn(OP_PD, 2 + NPAIR + 1, 0, 0);
        pulse_ack(3);

        txn(OP_ST, 20, 0, 0);
        toggle(260);
        txn(OP_ST, 1, 0, 0);

        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) toggle($urandom_range(1, 4));
            else if (r == 2) pulse_ack($urandom_range(0, NUM_CH - 1));
            else txn(16'(int'(CMD_BASE) - 1 + $urandom_range(0, NUM_CH + 3)),
                     $urandom_range(1, AW + 3), bit'($urandom_range(0, 1)), 0);
        end

        dq = {16'hAAAA};
        txn(OP_SET0 + 16'd3, 2, 0, 1);
        @(negedge clk_sys);
        #1;
        reset_n  = 1'b0;
        hps_rise = 1'b0;
        req_m    = '0;
        arg_m    = '0;
        rise_m   = 8'd0;
        for (int k = 0; k < NUM_CH; k++) ovr_m[k] = 0;
        expq.delete();
        #1;
        check_zero("midreset");
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        word(OP_ST, 1'b0, 16'd0);
        enable = 1'b0;
        @(posedge clk_sys);
        #1;
        dq = {16'hBEEF, 16'hCAFE};
        txn(OP_SET0 + 16'd3, AW + 1, 0, 0);
        check("post_reset_ch3_arg", cmd_arg[16*(3*AW) +: 32], 32'hCAFE_BEEF);
        txn(OP_ST, 3, 0, 0);

        repeat (3) @(posedge clk_sys);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
